fault_sequencer: RTL and testbench

FAULT_SEQUENCER -- requirements
Module: fault_sequencer

---
 rtl/fi_pkg.sv | 42 ++++
 rtl/fi_cmd_fifo.sv | 73 +++++++
 rtl/fault_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_fault_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fi_pkg.sv
// Shared fault-sequencer definitions: command layout, codes, FSM states.
// Latency: n/a (types, constants and pure decode helpers only).
// Backpressure: n/a.
package fi_pkg;

  // Command word layout, MSB first:
  // [31:28] component, [27:24] type, [23:14] target, [13:9] bit, [8:0] hold.
  typedef struct packed {
    logic [3:0] comp;
    logic [3:0] ftype;
    logic [9:0] target;
    logic [4:0] bit_idx;
    logic [8:0] hold;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  // Component codes. ALU (1) and control (3) exist in the system but cannot
  // be faulted by this block, so they decode as invalid.
  localparam logic [3:0] COMP_REGFILE = 4'd0;
  localparam logic [3:0] COMP_MEMORY  = 4'd2;
  localparam logic [3:0] COMP_INVALID = 4'hF;

  // Fault type codes; the low two bits drive *_fault_type directly.
  localparam logic [3:0] TYPE_FLIP = 4'd0;
  localparam logic [3:0] TYPE_SA0  = 4'd1;
  localparam logic [3:0] TYPE_SA1  = 4'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  function automatic logic comp_valid(input logic [3:0] comp);
    return (comp == COMP_REGFILE) || (comp == COMP_MEMORY);
  endfunction

  function automatic logic type_valid(input logic [3:0] ftype);
    return (ftype == TYPE_FLIP) || (ftype == TYPE_SA0) || (ftype == TYPE_SA1);
  endfunction

endpackage

// File: rtl/fi_cmd_fifo.sv
// Pending-command queue: power-of-two depth FIFO with flush.
// Latency: head is visible combinationally the cycle after a push lands.
// Backpressure: pushes while full and pops while empty are ignored.
module fi_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_dat_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_dat_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic             do_push, do_pop;

  assign full_o     = (lvl_q == LVL_W'(DEPTH));
  assign empty_o    = (lvl_q == '0);
  assign level_o    = lvl_q;
  assign head_dat_o = mem_q[rd_q];
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;

  // Pointer and occupancy next-state; flush wins over push/pop.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    lvl_d = lvl_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      lvl_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + PTR_W'(1);
      if (do_pop)  rd_d = rd_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   lvl_d = lvl_q + LVL_W'(1);
        2'b01:   lvl_d = lvl_q - LVL_W'(1);
        default: lvl_d = lvl_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_dat_i;
  end

endmodule

// File: rtl/fault_sequencer.sv
// Fault sequencer: queues fault commands, fires the head on trigger, drives regfile/memory fault ports.
// Latency: trigger at cycle N pops the head; decoded enable/target outputs appear at cycle N+1.
// Backpressure: cmd_ready drops while the queue is full; triggers in HOLD or on an empty queue are ignored.
module fault_sequencer
  import fi_pkg::*;
#(
  parameter int QUEUE_DEPTH = 4,
  parameter int ADDR_W      = 10,
  parameter int COUNT_W     = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [31:0]                  cmd_data,
  input  logic                         fault_trigger,
  input  logic                         abort,
  output logic                         regfile_fault_enable,
  output logic [4:0]                   regfile_target_reg,
  output logic [4:0]                   regfile_target_bit,
  output logic [1:0]                   regfile_fault_type,
  output logic                         memory_fault_enable,
  output logic [31:0]                  memory_target_addr,
  output logic [4:0]                   memory_target_bit,
  output logic [1:0]                   memory_fault_type,
  output logic                         fault_active,
  output logic [3:0]                   fault_component,
  output logic [COUNT_W-1:0]           fault_count,
  output logic [COUNT_W-1:0]           drop_count,
  output logic [$clog2(QUEUE_DEPTH):0] queue_level
);

  state_t             state_q, state_d;
  logic [8:0]         hold_q, hold_d;
  logic               rf_en_q, rf_en_d, mem_en_q, mem_en_d;
  logic [4:0]         rf_reg_q, rf_reg_d, rf_bit_q, rf_bit_d;
  logic [1:0]         rf_type_q, rf_type_d, mem_type_q, mem_type_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [4:0]         mem_bit_q, mem_bit_d;
  logic [3:0]         comp_q, comp_d;
  logic [COUNT_W-1:0] fcnt_q, fcnt_d, dcnt_q, dcnt_d;

  cmd_t               head;
  logic               fifo_full, fifo_empty;
  logic               push, pop;
  logic [31:0]        head_mem_addr;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + COUNT_W'(1);
  endfunction

  // Ready comes from registered occupancy only, so a same-cycle pop never
  // makes room for a push. Abort discards any push it coincides with.
  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && cmd_ready && !abort;

  fi_cmd_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (abort),
    .push_i     (push),
    .push_dat_i (cmd_data),
    .pop_i      (pop),
    .head_dat_o (head),
    .level_o    (queue_level),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  // Word index to byte address, zero-extended.
  assign head_mem_addr = {{(30 - ADDR_W){1'b0}}, head.target[ADDR_W-1:0], 2'b00};

  // Next-state, decode and counter update. Enables default low each cycle and
  // are only carried forward while a stuck-at hold is counting down.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    rf_en_d    = 1'b0;
    mem_en_d   = 1'b0;
    rf_reg_d   = rf_reg_q;
    rf_bit_d   = rf_bit_q;
    rf_type_d  = rf_type_q;
    mem_addr_d = mem_addr_q;
    mem_bit_d  = mem_bit_q;
    mem_type_d = mem_type_q;
    comp_d     = comp_q;
    fcnt_d     = fcnt_q;
    dcnt_d     = dcnt_q;
    pop        = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      hold_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fault_trigger && !fifo_empty) begin
            pop    = 1'b1;
            comp_d = comp_valid(head.comp) ? head.comp : COMP_INVALID;
            if (comp_valid(head.comp) && type_valid(head.ftype)) begin
              fcnt_d = sat_inc(fcnt_q);
              if (head.comp == COMP_REGFILE) begin
                rf_en_d   = 1'b1;
                rf_reg_d  = head.target[4:0];
                rf_bit_d  = head.bit_idx;
                rf_type_d = head.ftype[1:0];
              end else begin
                mem_en_d   = 1'b1;
                mem_addr_d = head_mem_addr;
                mem_bit_d  = head.bit_idx;
                mem_type_d = head.ftype[1:0];
              end
              if (head.ftype != TYPE_FLIP && head.hold != '0) begin
                state_d = ST_HOLD;
                hold_d  = head.hold;
              end
            end else begin
              dcnt_d = sat_inc(dcnt_q);
            end
          end
        end
        ST_HOLD: begin
          if (hold_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            rf_en_d  = rf_en_q;
            mem_en_d = mem_en_q;
            hold_d   = hold_q - 9'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, output and counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      rf_en_q    <= 1'b0;
      mem_en_q   <= 1'b0;
      rf_reg_q   <= '0;
      rf_bit_q   <= '0;
      rf_type_q  <= '0;
      mem_addr_q <= '0;
      mem_bit_q  <= '0;
      mem_type_q <= '0;
      comp_q     <= '0;
      fcnt_q     <= '0;
      dcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      rf_en_q    <= rf_en_d;
      mem_en_q   <= mem_en_d;
      rf_reg_q   <= rf_reg_d;
      rf_bit_q   <= rf_bit_d;
      rf_type_q  <= rf_type_d;
      mem_addr_q <= mem_addr_d;
      mem_bit_q  <= mem_bit_d;
      mem_type_q <= mem_type_d;
      comp_q     <= comp_d;
      fcnt_q     <= fcnt_d;
      dcnt_q     <= dcnt_d;
    end
  end

  assign regfile_fault_enable = rf_en_q;
  assign regfile_target_reg   = rf_reg_q;
  assign regfile_target_bit   = rf_bit_q;
  assign regfile_fault_type   = rf_type_q;
  assign memory_fault_enable  = mem_en_q;
  assign memory_target_addr   = mem_addr_q;
  assign memory_target_bit    = mem_bit_q;
  assign memory_fault_type    = mem_type_q;
  assign fault_active         = rf_en_q | mem_en_q;
  assign fault_component      = comp_q;
  assign fault_count          = fcnt_q;
  assign drop_count           = dcnt_q;

endmodule

// File: tb/tb_fault_sequencer.sv
// Scoreboard bench for fault_sequencer: directed scenarios then random traffic.
// Latency: each stimulus cycle queues the expected post-edge outputs; the monitor compares at the next negedge.
// Backpressure: the queue-based reference model decides which pushes the DUT must accept.
module tb_fault_sequencer;

  localparam int DEPTH = 4;
  localparam int AW    = 10;
  localparam int CW    = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, cmd_valid, cmd_ready, fault_trigger, abort;
  logic [31:0]   cmd_data;
  logic          regfile_fault_enable, memory_fault_enable, fault_active;
  logic [4:0]    regfile_target_reg, regfile_target_bit, memory_target_bit;
  logic [1:0]    regfile_fault_type, memory_fault_type;
  logic [31:0]   memory_target_addr;
  logic [3:0]    fault_component;
  logic [CW-1:0] fault_count, drop_count;
  logic [LW-1:0] queue_level;

  fault_sequencer #(.QUEUE_DEPTH(DEPTH), .ADDR_W(AW), .COUNT_W(CW)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .cmd_valid            (cmd_valid),
    .cmd_ready            (cmd_ready),
    .cmd_data             (cmd_data),
    .fault_trigger        (fault_trigger),
    .abort                (abort),
    .regfile_fault_enable (regfile_fault_enable),
    .regfile_target_reg   (regfile_target_reg),
    .regfile_target_bit   (regfile_target_bit),
    .regfile_fault_type   (regfile_fault_type),
    .memory_fault_enable  (memory_fault_enable),
    .memory_target_addr   (memory_target_addr),
    .memory_target_bit    (memory_target_bit),
    .memory_fault_type    (memory_fault_type),
    .fault_active         (fault_active),
    .fault_component      (fault_component),
    .fault_count          (fault_count),
    .drop_count           (drop_count),
    .queue_level          (queue_level)
  );

  typedef struct packed {
    logic          rf_en;
    logic [4:0]    rf_reg;
    logic [4:0]    rf_bit;
    logic [1:0]    rf_type;
    logic          mem_en;
    logic [31:0]   mem_addr;
    logic [4:0]    mem_bit;
    logic [1:0]    mem_type;
    logic          active;
    logic [3:0]    comp;
    logic [CW-1:0] fcnt;
    logic [CW-1:0] dcnt;
    logic [LW-1:0] level;
    logic          ready;
  } out_t;

  out_t        exp_q[$];
  out_t        mo;
  out_t        mon_e;
  logic [31:0] mq[$];
  int          hold_left = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          mem_on_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [3:0] comp, input logic [3:0] typ,
                                     input logic [9:0] tgt, input logic [4:0] bt,
                                     input logic [8:0] hold);
    return {comp, typ, tgt, bt, hold};
  endfunction

  // Reference model: a command queue plus a count of remaining hold cycles.
  task automatic model_step(input logic rn, input logic v, input logic [31:0] d,
                            input logic trg, input logic ab);
    int          lvl_before;
    logic [31:0] c;
    int          cp, ty, tg, hd;
    bit          ok_comp, ok_type;
    if (!rn) begin
      mq.delete();
      hold_left = 0;
      mo = '0;
    end else if (ab) begin
      mq.delete();
      hold_left = 0;
      mo.rf_en  = 1'b0;
      mo.mem_en = 1'b0;
    end else begin
      lvl_before = mq.size();
      if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) begin
          mo.rf_en  = 1'b0;
          mo.mem_en = 1'b0;
        end
      end else begin
        mo.rf_en  = 1'b0;
        mo.mem_en = 1'b0;
        if (trg && mq.size() > 0) begin
          c  = mq.pop_front();
          cp = int'(c[31:28]);
          ty = int'(c[27:24]);
          tg = int'(c[23:14]);
          hd = int'(c[8:0]);
          ok_comp = (cp == 0) || (cp == 2);
          ok_type = (ty <= 2);
          mo.comp = ok_comp ? 4'(cp) : 4'hF;
          if (ok_comp && ok_type) begin
            if (mo.fcnt != {CW{1'b1}}) mo.fcnt = mo.fcnt + CW'(1);
            if (cp == 0) begin
              mo.rf_en   = 1'b1;
              mo.rf_reg  = 5'(tg % 32);
              mo.rf_bit  = c[13:9];
              mo.rf_type = 2'(ty);
            end else begin
              mo.mem_en   = 1'b1;
              mo.mem_addr = 32'((tg % (1 << AW)) * 4);
              mo.mem_bit  = c[13:9];
              mo.mem_type = 2'(ty);
            end
            if (ty != 0 && hd != 0) hold_left = hd + 1;
          end else begin
            if (mo.dcnt != {CW{1'b1}}) mo.dcnt = mo.dcnt + CW'(1);
          end
        end
      end
      if (v && lvl_before < DEPTH) mq.push_back(d);
    end
    mo.level  = LW'(mq.size());
    mo.ready  = (mq.size() < DEPTH);
    mo.active = mo.rf_en | mo.mem_en;
    exp_q.push_back(mo);
  endtask

  // Monitor: compare every output against the expectation for this edge.
  always @(negedge clk) begin
    if (memory_fault_enable === 1'b1) mem_on_cnt++;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("rf_en",    regfile_fault_enable, mon_e.rf_en);
      chk("rf_reg",   regfile_target_reg,   mon_e.rf_reg);
      chk("rf_bit",   regfile_target_bit,   mon_e.rf_bit);
      chk("rf_type",  regfile_fault_type,   mon_e.rf_type);
      chk("mem_en",   memory_fault_enable,  mon_e.mem_en);
      chk("mem_addr", memory_target_addr,   mon_e.mem_addr);
      chk("mem_bit",  memory_target_bit,    mon_e.mem_bit);
      chk("mem_type", memory_fault_type,    mon_e.mem_type);
      chk("active",   fault_active,         mon_e.active);
      chk("comp",     fault_component,      mon_e.comp);
      chk("fcnt",     fault_count,          mon_e.fcnt);
      chk("dcnt",     drop_count,           mon_e.dcnt);
      chk("level",    queue_level,          mon_e.level);
      chk("ready",    cmd_ready,            mon_e.ready);
    end
  end

  task automatic cyc(input logic rn, input logic v, input logic [31:0] d,
                     input logic trg, input logic ab);
    rst_n         = rn;
    cmd_valid     = v;
    cmd_data      = d;
    fault_trigger = trg;
    abort         = ab;
    model_step(rn, v, d, trg, ab);
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [31:0] d);
    cyc(1'b1, 1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic trig();
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  logic [31:0] c35, c36, cb, rd;
  int          rc, rt;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_data = '0; fault_trigger = 1'b0; abort = 1'b0;
    c35 = 32'h00A0_8000;
    c36 = mk(4'd2, 4'd2, 10'h028, 5'h1F, 9'h1F4);
    cb  = mk(4'd2, 4'd0, 10'd5, 5'd1, 9'd0);
    @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_comp",  fault_component, 0);
    chk("rst_level", queue_level, 0);

    // Regfile bit flip: one enable cycle right after the trigger edge.
    push(c35);
    trig();
    chk("flip_en",   regfile_fault_enable, 1);
    chk("flip_reg",  regfile_target_reg, 2);
    chk("flip_bit",  regfile_target_bit, 0);
    chk("flip_type", regfile_fault_type, 0);
    chk("flip_fcnt", fault_count, 1);
    idle(1);
    chk("flip_off",  regfile_fault_enable, 0);
    chk("flip_hold_reg", regfile_target_reg, 2);

    // Memory stuck-at-1 hold 500 with a second command waiting; triggers ignored in HOLD.
    mem_on_cnt = 0;
    push(c36);
    push(c35);
    trig();
    chk("sa1_addr", memory_target_addr, 32'hA0);
    chk("sa1_type", memory_fault_type, 2);
    chk("sa1_bit",  memory_target_bit, 5'h1F);
    for (int i = 0; i < 500; i++) trig();
    idle(3);
    chk("sa1_cycles", mem_on_cnt, 501);
    chk("sa1_level",  queue_level, 1);
    trig();
    chk("sa1_next_fcnt", fault_count, 3);

    // Five pushes into a depth-4 queue, then drain in order.
    for (int i = 0; i < 5; i++) push(mk(4'd0, 4'd0, 10'(i + 1), 5'(i), 9'd0));
    chk("full_level", queue_level, 4);
    chk("full_ready", cmd_ready, 0);
    for (int i = 0; i < 4; i++) begin
      trig();
      chk("drain_reg", regfile_target_reg, i + 1);
    end
    chk("drain_level", queue_level, 0);

    // Invalid component and invalid type are dropped.
    push(mk(4'd1, 4'd0, 10'd3, 5'd3, 9'd0));
    push(mk(4'd2, 4'd7, 10'd3, 5'd3, 9'd0));
    trig();
    chk("drop1_comp", fault_component, 4'hF);
    chk("drop1_act",  fault_active, 0);
    trig();
    chk("drop2_comp", fault_component, 2);
    chk("drop2_dcnt", drop_count, 2);

    // Abort in the third cycle of a hold-10 stuck-at-0 with two commands queued.
    push(mk(4'd0, 4'd1, 10'd7, 5'd3, 9'd10));
    push(cb);
    push(cb);
    trig();
    idle(1);
    cyc(1'b1, 1'b1, cb, 1'b0, 1'b1);
    chk("abort_en",    regfile_fault_enable, 0);
    chk("abort_level", queue_level, 0);
    chk("abort_fcnt",  fault_count, 8);
    trig();
    chk("abort_idle",  fault_active, 0);

    // Reset in the middle of a memory hold.
    push(mk(4'd2, 4'd1, 10'h3FF, 5'd9, 9'd20));
    push(cb);
    trig();
    idle(3);
    chk("pre_rst_en", memory_fault_enable, 1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("mid_rst_en",    memory_fault_enable, 0);
    chk("mid_rst_level", queue_level, 0);
    chk("mid_rst_fcnt",  fault_count, 0);
    chk("mid_rst_addr",  memory_target_addr, 0);
    trig();
    chk("post_rst_trig", fault_active, 0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      rd = $urandom;
      rc = ($urandom_range(0, 9) < 8) ? (($urandom_range(0, 1) == 1) ? 2 : 0) : int'($urandom_range(0, 15));
      rt = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 15));
      rd[31:28] = 4'(rc);
      rd[27:24] = 4'(rt);
      rd[8:0]   = ($urandom_range(0, 3) == 0) ? 9'd0 : 9'($urandom_range(1, 12));
      cyc(($urandom_range(0, 999) >= 2), 1'($urandom_range(0, 1)), rd,
          ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 3));
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
